// File: rtl/la_pkg.sv
// Shared state encoding and default widths for the logic-analyzer capture controller.
package la_pkg;

   localparam int LA_ADDR_W = 10;
   localparam int LA_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRE_FILL = 3'd1,
      ST_ARMED    = 3'd2,
      ST_POST     = 3'd3,
      ST_DONE     = 3'd4
   } la_state_e;

endpackage

// File: rtl/la_win_cnt.sv
// Window counter: loads a limit and clears the count together, then counts qualified
// samples; o_last flags that the next increment reaches the limit.
module la_win_cnt #(
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_limit,
   input  logic              i_clr,
   input  logic              i_inc,
   output logic              o_last
);

   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] r_limit;
   logic [ADDR_W-1:0] w_cnt_inc;

   assign w_cnt_inc = r_cnt + ADDR_W'(1);
   assign o_last    = (w_cnt_inc == r_limit);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_limit <= '0;
      end else if (i_load) begin
         r_cnt   <= '0;
         r_limit <= i_limit;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= w_cnt_inc;
      end
   end

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture controller: writes qualified samples into the circular sample RAM, arms the
// trigger once the pre-trigger window is filled, and counts out the post-trigger window.
module la_capture_ctrl
   import la_pkg::*;
#(
   parameter int ADDR_W = LA_ADDR_W,
   parameter int DATA_W = LA_DATA_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic              SAMPLE_EN,
   input  logic              TRIG_IN,
   input  logic              START,
   input  logic              ABORT,
   input  logic [ADDR_W-1:0] PRE_CNT,
   input  logic [ADDR_W-1:0] POST_CNT,
   output logic              TRIG_EN,
   output logic              WR_EN,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [DATA_W-1:0] WR_DATA,
   output logic [ADDR_W-1:0] TRIG_ADDR,
   output logic              BUSY,
   output logic              DONE,
   output logic [2:0]        STATE
);

   la_state_e         r_state;
   la_state_e         w_next;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [ADDR_W-1:0] r_trig_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_wr_en;
   logic              r_trig_en;
   logic              r_busy;
   logic              r_done;
   logic              r_post_zero;

   logic              w_start_ok;
   logic              w_load;
   logic              w_take_trig;
   logic              w_write;
   logic              w_pre_inc;
   logic              w_post_inc;
   logic              w_pre_last;
   logic              w_post_last;

   la_win_cnt #(.ADDR_W(ADDR_W)) u_pre_cnt (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_load  (w_load),
      .i_limit (PRE_CNT),
      .i_clr   (ABORT),
      .i_inc   (w_pre_inc),
      .o_last  (w_pre_last)
   );

   la_win_cnt #(.ADDR_W(ADDR_W)) u_post_cnt (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_load  (w_load),
      .i_limit (POST_CNT),
      .i_clr   (ABORT),
      .i_inc   (w_post_inc),
      .o_last  (w_post_last)
   );

   always_comb begin
      w_start_ok  = START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
      w_load      = w_start_ok && !ABORT;
      w_take_trig = (r_state == ST_ARMED) && TRIG_IN && !ABORT;
      // A trigger with an empty post window finishes immediately and drops that sample.
      w_write     = SAMPLE_EN && !ABORT &&
                    ((r_state == ST_PRE_FILL) || (r_state == ST_POST) ||
                     ((r_state == ST_ARMED) && !(TRIG_IN && r_post_zero)));
      w_pre_inc   = w_write && (r_state == ST_PRE_FILL);
      w_post_inc  = w_write && ((r_state == ST_POST) || w_take_trig);

      w_next = r_state;
      if (ABORT) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start_ok) w_next = (PRE_CNT == '0) ? ST_ARMED : ST_PRE_FILL;
            end
            ST_PRE_FILL: begin
               if (w_pre_inc && w_pre_last) w_next = ST_ARMED;
            end
            ST_ARMED: begin
               if (w_take_trig) begin
                  if (r_post_zero || (w_post_inc && w_post_last)) w_next = ST_DONE;
                  else                                           w_next = ST_POST;
               end
            end
            ST_POST: begin
               if (w_post_inc && w_post_last) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_trig_addr <= '0;
         r_wr_en     <= 1'b0;
         r_trig_en   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_post_zero <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_trig_en <= (w_next == ST_ARMED);
         r_busy    <= (w_next == ST_PRE_FILL) || (w_next == ST_ARMED) || (w_next == ST_POST);
         r_done    <= (w_next == ST_DONE);
         r_wr_en   <= w_write;
         if (w_write) begin
            r_wr_addr <= r_ptr;
            r_wr_data <= DATA_IN;
            r_ptr     <= r_ptr + ADDR_W'(1);
         end
         if (w_load) begin
            r_ptr       <= '0;
            r_trig_addr <= '0;
            r_post_zero <= (POST_CNT == '0);
         end
         if (w_take_trig) begin
            r_trig_addr <= r_ptr;
         end
      end
   end

   assign TRIG_EN   = r_trig_en;
   assign WR_EN     = r_wr_en;
   assign WR_ADDR   = r_wr_addr;
   assign WR_DATA   = r_wr_data;
   assign TRIG_ADDR = r_trig_addr;
   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign STATE     = r_state;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Bench for la_capture_ctrl: directed captures, RAM writes checked against an expected queue.
module tb_la_capture_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic [DW-1:0] DATA_IN;
   logic          SAMPLE_EN;
   logic          TRIG_IN;
   logic          START;
   logic          ABORT;
   logic [AW-1:0] PRE_CNT;
   logic [AW-1:0] POST_CNT;
   logic          TRIG_EN;
   logic          WR_EN;
   logic [AW-1:0] WR_ADDR;
   logic [DW-1:0] WR_DATA;
   logic [AW-1:0] TRIG_ADDR;
   logic          BUSY;
   logic          DONE;
   logic [2:0]    STATE;

   int total = 0;
   int bad   = 0;
   logic [DW-1:0]    tb_data = 8'h10;
   logic [AW+DW-1:0] exp_q[$];

   la_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .DATA_IN   (DATA_IN),
      .SAMPLE_EN (SAMPLE_EN),
      .TRIG_IN   (TRIG_IN),
      .START     (START),
      .ABORT     (ABORT),
      .PRE_CNT   (PRE_CNT),
      .POST_CNT  (POST_CNT),
      .TRIG_EN   (TRIG_EN),
      .WR_EN     (WR_EN),
      .WR_ADDR   (WR_ADDR),
      .WR_DATA   (WR_DATA),
      .TRIG_ADDR (TRIG_ADDR),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .STATE     (STATE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle of stimulus; when push is set the write it must cause is queued first.
   task automatic step(input logic se, input logic tr, input logic push, input logic [AW-1:0] a);
      SAMPLE_EN = se;
      TRIG_IN   = tr;
      DATA_IN   = tb_data;
      if (push) exp_q.push_back({a, tb_data});
      tb_data = tb_data + 8'd7;
      @(posedge CLK);
      #1;
      START = 1'b0;
      ABORT = 1'b0;
   endtask

   task automatic start_cap(input logic [AW-1:0] pre, input logic [AW-1:0] post);
      PRE_CNT  = pre;
      POST_CNT = post;
      START    = 1'b1;
      step(1'b1, 1'b0, 1'b0, '0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},     32'(STATE),     32'd0);
      chk({tag, "_trig_en"},   32'(TRIG_EN),   32'd0);
      chk({tag, "_wr_en"},     32'(WR_EN),     32'd0);
      chk({tag, "_wr_addr"},   32'(WR_ADDR),   32'd0);
      chk({tag, "_wr_data"},   32'(WR_DATA),   32'd0);
      chk({tag, "_trig_addr"}, 32'(TRIG_ADDR), 32'd0);
      chk({tag, "_busy"},      32'(BUSY),      32'd0);
      chk({tag, "_done"},      32'(DONE),      32'd0);
   endtask

   // Monitor: every asserted write strobe must match the oldest queued write.
   always @(negedge CLK) begin
      if (WR_EN === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", WR_ADDR, WR_DATA);
         end else begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            if ({WR_ADDR, WR_DATA} !== e) begin
               bad++;
               $display("FAIL wr_match: got addr %0h data %0h expected addr %0h data %0h",
                        WR_ADDR, WR_DATA, e[AW+DW-1:DW], e[DW-1:0]);
            end
         end
      end
   end

   initial begin
      RST = 1'b1; SAMPLE_EN = 1'b0; TRIG_IN = 1'b0; START = 1'b0; ABORT = 1'b0;
      DATA_IN = '0; PRE_CNT = '0; POST_CNT = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk_reset_vals("rst");
      RST = 1'b0;

      // Idle with toggling SAMPLE_EN: nothing may be written.
      for (int i = 0; i < 20; i++) step(i[0], 1'b0, 1'b0, '0);
      chk("idle_state", 32'(STATE), 32'd0);
      chk("idle_busy",  32'(BUSY),  32'd0);

      // Basic capture, trigger held high from the start.
      start_cap(4'd4, 4'd3);
      chk("basic_state_pre", 32'(STATE), 32'd1);
      chk("basic_busy",      32'(BUSY),  32'd1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b1, AW'(i));
         chk("basic_trig_en_pre", 32'(TRIG_EN), 32'(i == 3));
      end
      chk("basic_state_armed", 32'(STATE), 32'd2);
      step(1'b1, 1'b1, 1'b1, 4'd4);
      chk("basic_state_post", 32'(STATE),     32'd3);
      chk("basic_trig_addr",  32'(TRIG_ADDR), 32'd4);
      chk("basic_trig_en_lo", 32'(TRIG_EN),   32'd0);
      step(1'b1, 1'b1, 1'b1, 4'd5);
      step(1'b1, 1'b1, 1'b1, 4'd6);
      chk("basic_done",      32'(DONE),  32'd1);
      chk("basic_last_wr",   32'(WR_EN), 32'd1);
      chk("basic_busy_lo",   32'(BUSY),  32'd0);
      chk("basic_state_done", 32'(STATE), 32'd4);
      step(1'b1, 1'b0, 1'b0, '0);
      chk("basic_wr_en_lo",  32'(WR_EN),     32'd0);
      chk("basic_addr_hold", 32'(WR_ADDR),   32'd6);
      chk("basic_done_hold", 32'(DONE),      32'd1);
      chk("basic_trig_hold", 32'(TRIG_ADDR), 32'd4);

      // Wrap: 20 armed samples before the trigger.
      start_cap(4'd2, 4'd2);
      step(1'b1, 1'b0, 1'b1, 4'd0);
      step(1'b1, 1'b0, 1'b1, 4'd1);
      chk("wrap_trig_en", 32'(TRIG_EN), 32'd1);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, AW'((2 + i) % 16));
      chk("wrap_still_armed", 32'(STATE), 32'd2);
      step(1'b1, 1'b1, 1'b1, 4'd6);
      chk("wrap_trig_addr", 32'(TRIG_ADDR), 32'd6);
      chk("wrap_state_post", 32'(STATE), 32'd3);
      step(1'b1, 1'b0, 1'b1, 4'd7);
      chk("wrap_done",    32'(DONE),    32'd1);
      chk("wrap_wr_addr", 32'(WR_ADDR), 32'd7);

      // Zero windows: straight to ARMED, trigger goes to DONE without a write.
      start_cap(4'd0, 4'd0);
      chk("zero_state_armed", 32'(STATE),     32'd2);
      chk("zero_trig_en",     32'(TRIG_EN),   32'd1);
      chk("zero_trig_clr",    32'(TRIG_ADDR), 32'd0);
      step(1'b1, 1'b1, 1'b0, '0);
      chk("zero_state_done", 32'(STATE),     32'd4);
      chk("zero_done",       32'(DONE),      32'd1);
      chk("zero_wr_en",      32'(WR_EN),     32'd0);
      chk("zero_trig_addr",  32'(TRIG_ADDR), 32'd0);
      chk("zero_trig_en_lo", 32'(TRIG_EN),   32'd0);

      // Gapped samples, trigger pulse during PRE_FILL must be ignored.
      start_cap(4'd3, 4'd1);
      for (int i = 0; i < 9; i++) begin
         step(1'((i % 3) == 2), 1'(i == 0), 1'((i % 3) == 2), AW'(i / 3));
         if (i == 0) chk("gap_ignore_trig", 32'(STATE), 32'd1);
         chk("gap_trig_en", 32'(TRIG_EN), 32'(i == 8));
      end
      step(1'b1, 1'b1, 1'b1, 4'd3);
      chk("gap_state_done", 32'(STATE),     32'd4);
      chk("gap_trig_addr",  32'(TRIG_ADDR), 32'd3);

      // ABORT together with START while in POST.
      start_cap(4'd1, 4'd3);
      step(1'b1, 1'b0, 1'b1, 4'd0);
      step(1'b1, 1'b1, 1'b1, 4'd1);
      chk("abort_in_post", 32'(STATE), 32'd3);
      ABORT = 1'b1;
      START = 1'b1;
      step(1'b1, 1'b0, 1'b0, '0);
      chk("abort_state",     32'(STATE),     32'd0);
      chk("abort_done",      32'(DONE),      32'd0);
      chk("abort_wr_en",     32'(WR_EN),     32'd0);
      chk("abort_busy",      32'(BUSY),      32'd0);
      chk("abort_trig_en",   32'(TRIG_EN),   32'd0);
      chk("abort_trig_hold", 32'(TRIG_ADDR), 32'd1);

      // RST while ARMED.
      start_cap(4'd0, 4'd2);
      chk("rstarm_armed", 32'(STATE), 32'd2);
      step(1'b1, 1'b0, 1'b1, 4'd0);
      RST = 1'b1;
      step(1'b1, 1'b1, 1'b0, '0);
      chk_reset_vals("rstarm");
      RST = 1'b0;

      repeat (3) @(posedge CLK);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/la_capture_ctrl.md
# la_capture_ctrl

Logic-analyzer capture controller sitting directly downstream of the LA trigger block. It writes qualified 8-bit samples into the circular sample RAM and gates the trigger's enable so triggers are honoured only after the pre-trigger window is full. It records the trigger position and counts the post-trigger samples, then signals completion to the host interface.

## Interface
Parameters:
- ADDR_W, 10, sample RAM address width (depth = 2^ADDR_W)
- DATA_W, 8, sample width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK  in  1  capture clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- DATA_IN  in  DATA_W  sample bus (same bus that feeds the trigger)
- SAMPLE_EN  in  1  sample qualifier from decimator; one sample per high cycle
- TRIG_IN  in  1  trigger request from the LA trigger block
- START  in  1  one-cycle pulse, begin capture
- ABORT  in  1  one-cycle pulse, cancel capture
- PRE_CNT  in  ADDR_W  pre-trigger samples, sampled on START
- POST_CNT  in  ADDR_W  post-trigger samples, sampled on START
- TRIG_EN  out  1  enable to the trigger block
- WR_EN  out  1  RAM write strobe
- WR_ADDR  out  ADDR_W  RAM write address
- WR_DATA  out  DATA_W  RAM write data
- TRIG_ADDR  out  ADDR_W  address of the first post-trigger sample
- BUSY  out  1  high in PRE_FILL, ARMED or POST
- DONE  out  1  high in DONE state
- STATE  out  3  current state encoding for status readback

## Operation
- States: IDLE(0), PRE_FILL(1), ARMED(2), POST(3), DONE(4).
- IDLE or DONE with START: latch PRE_CNT and POST_CNT, clear write pointer, counters and TRIG_ADDR, clear DONE. Next state is PRE_FILL, or ARMED if PRE_CNT = 0.
- Write rule: in PRE_FILL, ARMED or POST, SAMPLE_EN=1 registers WR_DATA<=DATA_IN, WR_ADDR<=ptr and WR_EN<=1, then ptr<=ptr+1 mod 2^ADDR_W. In all other cases WR_EN<=0 and WR_ADDR/WR_DATA hold.
- PRE_FILL: each write increments pre_cnt. The write that makes pre_cnt equal PRE_CNT moves the state to ARMED. TRIG_IN is ignored, because the trigger block's output reads high out of its own reset.
- ARMED: writes continue circularly, with no wrap limit. TRIG_IN=1 latches TRIG_ADDR<=ptr and moves the state to POST; with POST_CNT = 0 it moves to DONE and no write occurs that cycle.
- POST: a write in the trigger cycle counts as post sample 1. The write that makes post_cnt equal POST_CNT moves the state to DONE.
- DONE: WR_EN=0. WR_ADDR, TRIG_ADDR and WR_DATA hold until the next START.
- ABORT in any state: next state IDLE, WR_EN<=0, DONE<=0, TRIG_ADDR held. If ABORT and START occur in the same cycle, ABORT wins.
- Counters are ADDR_W wide. PRE_CNT+POST_CNT > 2^ADDR_W is not checked; oldest pre-trigger data is overwritten.
- TRIG_EN<=1 only while the next state is ARMED, so it rises in the first ARMED cycle and falls in the first POST/DONE cycle.

## Timing
- Reset values: state IDLE (STATE=0), TRIG_EN=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, TRIG_ADDR=0, BUSY=0, DONE=0.
- START to BUSY: 1 cycle. START to the first possible WR_EN: 2 cycles, because the first SAMPLE_EN is accepted in the cycle after START.
- SAMPLE_EN to WR_EN/WR_ADDR/WR_DATA: 1 cycle, fully registered.
- TRIG_IN to STATE=POST and TRIG_EN=0: 1 cycle. TRIG_IN is honoured only when the current state is ARMED. The trigger block adds its own 2-cycle pipeline delay; this block does not compensate.
- Last POST write to DONE=1: same edge that asserts that WR_EN.
- RST mid-capture overrides everything on the next edge and returns to the reset values.

## Structure
- Package la_pkg: state encoding constants (ST_IDLE..ST_DONE, 3 bits), default ADDR_W/DATA_W.
- One sub-module, la_win_cnt: ADDR_W loadable counter with clear, increment enable and an equality-to-limit output. It is instanced twice, for pre and post.
- FSM and write pointer live in the top module.

## Test plan
- Reset then idle: RST for 2 cycles, then no START for 20 cycles with SAMPLE_EN toggling -> all outputs 0, no WR_EN.
- Basic capture: ADDR_W=4, PRE_CNT=4, POST_CNT=3, SAMPLE_EN always 1, TRIG_IN held 1 throughout.
  - Expect writes to addresses 0–3 in PRE_FILL.
  - TRIG_EN rises after the address-3 write.
  - Trigger taken in the first ARMED cycle, TRIG_ADDR=4.
  - Writes to addresses 4–6, then DONE=1 and WR_EN=0.
- Wrap: ADDR_W=4, PRE_CNT=2, POST_CNT=2, trigger after 20 ARMED samples -> WR_ADDR wraps 15->0, TRIG_ADDR=(22 mod 16)=6, last write address 7.
- Zero windows: PRE_CNT=0, POST_CNT=0 -> START goes straight to ARMED; on TRIG_IN go to DONE with no write; TRIG_ADDR=0.
- Gapped samples: SAMPLE_EN high every third cycle, PRE_CNT=3 -> exactly 3 writes before TRIG_EN; TRIG_IN pulsed in PRE_FILL is ignored.
- Abort/reset mid-operation: ABORT together with START while in POST -> IDLE next cycle, DONE=0, WR_EN=0. RST asserted in ARMED -> all reset values on the next edge.
